// File: rtl/order_store_ctrl.sv
// Order table: insert / find-by-id / scan-all / clear over valid-ready command and response channels.
// Optional ORDER_STORE_DUP_CHECK_EN makes INSERT search first and reject ids already present.
module order_store_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 32,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ID_W-1:0]          cmd_id,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_status,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] OP_INSERT = 2'd0;
  localparam logic [1:0] OP_FIND   = 2'd1;
  localparam logic [1:0] OP_SCAN   = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_NOT_FOUND = 2'd1;
  localparam logic [1:0] ST_FULL      = 2'd2;
  localparam logic [1:0] ST_DUP       = 2'd3;

`ifdef ORDER_STORE_DUP_CHECK_EN
  localparam bit DUP_CHK = 1'b1;
`else
  localparam bit DUP_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, SCAN, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;

  logic [ID_W-1:0]     tbl_id_q   [DEPTH];
  logic [DATA_W-1:0]   tbl_data_q [DEPTH];

  logic                wr_en;
  logic [ID_W-1:0]     wr_id;
  logic [DATA_W-1:0]   wr_data;
  logic                full;
  logic                hit;
  logic [CNT_W-1:0]    cnt_m1;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    nxt_idx;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign cnt_m1   = count_q - CNT_W'(1);
  assign last_idx = cnt_m1[IDX_W-1:0];
  assign nxt_idx  = idx_q + IDX_W'(1);
  assign hit      = (tbl_id_q[idx_q] == id_q);

  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign count      = count_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    op_d         = op_q;
    id_d         = id_q;
    data_d       = data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_last_d   = rsp_last_q;
    wr_en        = 1'b0;
    wr_id        = cmd_id;
    wr_data      = cmd_data;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d         = cmd_op;
          id_d         = cmd_id;
          data_d       = cmd_data;
          idx_d        = '0;
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_last_d   = 1'b1;
          rsp_status_d = ST_OK;
          rsp_id_d     = '0;
          rsp_data_d   = '0;
          case (cmd_op)
            OP_INSERT: begin
              // FULL is decided before any duplicate search
              if (full) begin
                rsp_status_d = ST_FULL;
              end else if (DUP_CHK && (count_q != '0)) begin
                state_d     = SEARCH;
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
              end else begin
                wr_en      = 1'b1;
                count_d    = count_q + CNT_W'(1);
                rsp_id_d   = cmd_id;
                rsp_data_d = cmd_data;
              end
            end
            OP_FIND: begin
              if (count_q == '0) begin
                rsp_status_d = ST_NOT_FOUND;
              end else begin
                state_d     = SEARCH;
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
              end
            end
            OP_SCAN: begin
              if (count_q == '0) begin
                rsp_status_d = ST_NOT_FOUND;
              end else begin
                state_d    = SCAN;
                rsp_id_d   = tbl_id_q[0];
                rsp_data_d = tbl_data_q[0];
                rsp_last_d = (count_q == CNT_W'(1));
              end
            end
            default: count_d = '0;
          endcase
        end
      end

      SEARCH: begin
        if (hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          if (op_q == OP_FIND) begin
            rsp_status_d = ST_OK;
            rsp_id_d     = tbl_id_q[idx_q];
            rsp_data_d   = tbl_data_q[idx_q];
          end else begin
            rsp_status_d = ST_DUP;
            rsp_id_d     = '0;
            rsp_data_d   = '0;
          end
        end else if (idx_q == last_idx) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          if (op_q == OP_FIND) begin
            rsp_status_d = ST_NOT_FOUND;
            rsp_id_d     = '0;
            rsp_data_d   = '0;
          end else begin
            // duplicate search missed: the deferred insert happens now
            wr_en        = 1'b1;
            wr_id        = id_q;
            wr_data      = data_q;
            count_d      = count_q + CNT_W'(1);
            rsp_status_d = ST_OK;
            rsp_id_d     = id_q;
            rsp_data_d   = data_q;
          end
        end else begin
          idx_d = nxt_idx;
        end
      end

      SCAN: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d      = IDLE;
            rsp_valid_d  = 1'b0;
            rsp_status_d = ST_OK;
            rsp_id_d     = '0;
            rsp_data_d   = '0;
            rsp_last_d   = 1'b0;
          end else begin
            idx_d      = nxt_idx;
            rsp_id_d   = tbl_id_q[nxt_idx];
            rsp_data_d = tbl_data_q[nxt_idx];
            rsp_last_d = (nxt_idx == last_idx);
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_status_d = ST_OK;
          rsp_id_d     = '0;
          rsp_data_d   = '0;
          rsp_last_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      op_q         <= '0;
      id_q         <= '0;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      op_q         <= op_d;
      id_q         <= id_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  // Table storage is never read beyond count, so it needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_id_q[count_q[IDX_W-1:0]]   <= wr_id;
      tbl_data_q[count_q[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule
